// File: rtl/alu_result_skid.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_skid
// Description : Two-entry skid buffer between the ALU and the memory/writeback
//               stage. Carries R, zero, ovf and the destination tag with a
//               valid/ready handshake and counts retired results. in_ready is
//               decoded from state flops only, so there is no combinational
//               path from out_ready to in_ready.
//               Optional macro OVF_TRAP_EN: overflowing results are consumed
//               but not stored, and they raise a sticky trap_flag instead.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_skid #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_r,
    input  logic             in_zero,
    input  logic             in_ovf,
    input  logic [RD_W-1:0]  in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_r,
    output logic             out_zero,
    output logic             out_ovf,
    output logic [RD_W-1:0]  out_rd,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] retired,
    output logic             trap_flag,
    input  logic             trap_clr
);

    localparam int ENT_W = WIDTH + RD_W + 2;

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [ENT_W-1:0]   head_q;
    logic [ENT_W-1:0]   skid_q;
    logic [ENT_W-1:0]   in_entry;
    logic               push;
    logic               pop;
    logic               store;
    logic               load_head_in;
    logic               load_head_skid;
    logic               load_skid;
    logic               clear_head;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign occupancy = state_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign in_entry  = {in_r, in_zero, in_ovf, in_rd};

    assign {out_r, out_zero, out_ovf, out_rd} = head_q;

`ifdef OVF_TRAP_EN
    logic trap_q;

    // An overflowing result is accepted but dropped; only clean results enter the buffer.
    assign store     = push & ~in_ovf;
    assign trap_flag = trap_q;

    // Sticky trap: a new overflow push wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trap_q <= 1'b0;
        end else if (push && in_ovf) begin
            trap_q <= 1'b1;
        end else if (trap_clr) begin
            trap_q <= 1'b0;
        end
    end
`else
    logic unused_trap_clr;

    assign store           = push;
    assign trap_flag       = 1'b0;
    assign unused_trap_clr = trap_clr;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath load decode; flush overrides any push/pop move.
    always_comb begin
        state_d        = state_q;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        clear_head     = 1'b0;
        case (state_q)
            EMPTY: begin
                if (store) begin
                    state_d      = ONE;
                    load_head_in = 1'b1;
                end
            end
            ONE: begin
                if (store && pop) begin
                    load_head_in = 1'b1;
                end else if (store) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d        = ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        if (flush) begin
            state_d        = EMPTY;
            load_head_in   = 1'b0;
            load_head_skid = 1'b0;
            load_skid      = 1'b0;
            clear_head     = 1'b1;
        end
    end

    // Head entry drives out_*; cleared on flush so discarded data never shows.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q <= '0;
        end else if (clear_head) begin
            head_q <= '0;
        end else if (load_head_in) begin
            head_q <= in_entry;
        end else if (load_head_skid) begin
            head_q <= skid_q;
        end
    end

    // Skid entry holds the second result while the head is stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_q <= '0;
        end else if (load_skid) begin
            skid_q <= in_entry;
        end
    end

    // Retired-result counter, one per output handshake, wrapping naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired <= '0;
        end else if (pop) begin
            retired <= retired + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_result_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_skid
// Description : Directed self-checking bench for alu_result_skid. Covers
//               reset state, single transfer, stall absorption, streaming,
//               flush, asynchronous reset mid-stall and overflow handling
//               (with or without OVF_TRAP_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_skid;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_r;
    logic        in_zero;
    logic        in_ovf;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_r;
    logic        out_zero;
    logic        out_ovf;
    logic [4:0]  out_rd;
    logic [1:0]  occupancy;
    logic [15:0] retired;
    logic        trap_flag;
    logic        trap_clr;

    int total;
    int bad;
    bit r_done;

    alu_result_skid #(
        .WIDTH (32),
        .RD_W  (5),
        .CNT_W (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_zero   (in_zero),
        .in_ovf    (in_ovf),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf),
        .out_rd    (out_rd),
        .occupancy (occupancy),
        .retired   (retired),
        .trap_flag (trap_flag),
        .trap_clr  (trap_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        if (!r_done) begin
            $error("FAIL timeout: test did not complete in time");
            $finish;
        end
    end

    initial begin
        total     = 0;
        bad       = 0;
        r_done    = 1'b0;
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_r      = '0;
        in_zero   = 1'b0;
        in_ovf    = 1'b0;
        in_rd     = '0;
        out_ready = 1'b0;
        trap_clr  = 1'b0;

        // Reset state.
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_r", out_r, 32'h0);
        check("rst_occ", occupancy, 2'd0);
        check("rst_retired", retired, 16'd0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_trap", trap_flag, 1'b0);
        #10;
        reset = 1'b1;

        // 1: single transfer, latency 1.
        in_valid  = 1'b1;
        in_r      = 32'h5;
        in_rd     = 5'd3;
        in_zero   = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_zero  = 1'b0;
        check("t1_out_valid", out_valid, 1'b1);
        check("t1_out_r", out_r, 32'h5);
        check("t1_out_rd", out_rd, 5'd3);
        check("t1_out_zero", out_zero, 1'b1);
        check("t1_occ", occupancy, 2'd1);
        tick();
        check("t1_drained", out_valid, 1'b0);
        check("t1_retired", retired, 16'd1);

        // 2: absorb a stall, then drain in order.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_r      = 32'hA;
        in_rd     = 5'd10;
        tick();
        in_r  = 32'hB;
        in_rd = 5'd11;
        tick();
        in_valid = 1'b0;
        check("t2_occ_full", occupancy, 2'd2);
        check("t2_in_ready_full", in_ready, 1'b0);
        check("t2_head_a", out_r, 32'hA);
        check("t2_head_a_rd", out_rd, 5'd10);
        tick();
        check("t2_stall_stable", out_r, 32'hA);
        out_ready = 1'b1;
        tick();
        check("t2_head_b", out_r, 32'hB);
        check("t2_head_b_rd", out_rd, 5'd11);
        check("t2_in_ready_after", in_ready, 1'b1);
        check("t2_occ_one", occupancy, 2'd1);
        tick();
        check("t2_empty", out_valid, 1'b0);
        check("t2_retired", retired, 16'd3);

        // 3: streaming push+pop for 100 cycles.
        out_ready = 1'b1;
        for (int i = 0; i <= 100; i++) begin
            in_valid = (i < 100);
            in_r     = 32'h100 + i;
            in_rd    = 5'(i);
            if (i > 0) begin
                check("t3_valid", out_valid, 1'b1);
                check("t3_data", out_r, 32'h100 + i - 1);
            end else begin
                check("t3_valid0", out_valid, 1'b0);
            end
            tick();
            if (i < 100) begin
                check("t3_occ", occupancy, 2'd1);
            end
        end
        in_valid = 1'b0;
        check("t3_occ_end", occupancy, 2'd0);
        check("t3_retired", retired, 16'd103);

        // 4: flush a full buffer while a push is offered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_r      = 32'h11;
        tick();
        in_r = 32'h22;
        tick();
        check("t4_full", occupancy, 2'd2);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_r     = 32'hDEAD;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t4_occ", occupancy, 2'd0);
        check("t4_out_valid", out_valid, 1'b0);
        check("t4_no_flushed_data", out_r, 32'h0);
        check("t4_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        tick();
        check("t4_still_empty", out_valid, 1'b0);
        check("t4_retired", retired, 16'd103);

        // 5: asynchronous reset in the middle of a stall.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_r      = 32'h31;
        tick();
        in_r = 32'h32;
        tick();
        in_valid = 1'b0;
        check("t5_full", occupancy, 2'd2);
        #2;
        reset = 1'b0;
        #1;
        check("t5_out_valid", out_valid, 1'b0);
        check("t5_out_r", out_r, 32'h0);
        check("t5_occ", occupancy, 2'd0);
        check("t5_retired", retired, 16'd0);
        check("t5_in_ready", in_ready, 1'b1);
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_r      = 32'h1;
        in_rd     = 5'd1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t5_out_r_after", out_r, 32'h1);
        check("t5_valid_after", out_valid, 1'b1);
        tick();
        check("t5_retired_after", retired, 16'd1);

        // 6: overflow result.
        in_valid  = 1'b1;
        in_ovf    = 1'b1;
        in_r      = 32'h77;
        in_rd     = 5'd7;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_ovf   = 1'b0;
`ifdef OVF_TRAP_EN
        check("t6_no_emit", out_valid, 1'b0);
        check("t6_trap_set", trap_flag, 1'b1);
        check("t6_occ", occupancy, 2'd0);
        trap_clr = 1'b1;
        tick();
        trap_clr = 1'b0;
        check("t6_trap_clr", trap_flag, 1'b0);
        check("t6_retired", retired, 16'd1);
`else
        check("t6_emit", out_valid, 1'b1);
        check("t6_out_ovf", out_ovf, 1'b1);
        check("t6_out_r", out_r, 32'h77);
        check("t6_trap_tied", trap_flag, 1'b0);
        tick();
        check("t6_retired", retired, 16'd2);
        check("t6_drained", out_valid, 1'b0);
`endif

        r_done = 1'b1;
        if (bad != 0) begin
            $error("FAIL summary: %0d of %0d checks failed", bad, total);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
